// File: rtl/sram_axi_bridge_if.sv
// AXI3 bus bundle between the SRAM-like bridge (master) and the SoC crossbar (slave).
interface sram_axi_bridge_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [3:0]        arid;
  logic [ADDR_W-1:0] araddr;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic [1:0]        arlock;
  logic [3:0]        arcache;
  logic [2:0]        arprot;
  logic              arvalid;
  logic              arready;

  logic [3:0]        rid;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rlast;
  logic              rvalid;
  logic              rready;

  logic [3:0]        awid;
  logic [ADDR_W-1:0] awaddr;
  logic [7:0]        awlen;
  logic [2:0]        awsize;
  logic [1:0]        awburst;
  logic [1:0]        awlock;
  logic [3:0]        awcache;
  logic [2:0]        awprot;
  logic              awvalid;
  logic              awready;

  logic [3:0]        wid;
  logic [DATA_W-1:0] wdata;
  logic [3:0]        wstrb;
  logic              wlast;
  logic              wvalid;
  logic              wready;

  logic [3:0]        bid;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready,
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    input  awready,
    output wid, wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready,
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    output awready,
    input  wid, wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready
  );
endinterface

// File: rtl/sram_axi_bridge.sv
// Merges the core's instruction and data SRAM-like ports onto one AXI3 master:
// single AR slot with data priority, per-ID read return, one outstanding write.
module sram_axi_bridge #(
  parameter int         ADDR_W   = 32,
  parameter int         DATA_W   = 32,
  parameter int         RD_DEPTH = 2,
  parameter logic [3:0] INST_ID  = 4'd0,
  parameter logic [3:0] DATA_ID  = 4'd1
) (
  input  logic              aclk,
  input  logic              aresetn,

  input  logic              inst_sram_req,
  input  logic [1:0]        inst_sram_size,
  input  logic [ADDR_W-1:0] inst_sram_addr,
  output logic              inst_sram_addr_ok,
  output logic              inst_sram_data_ok,
  output logic [DATA_W-1:0] inst_sram_rdata,

  input  logic              data_sram_req,
  input  logic              data_sram_wr,
  input  logic [1:0]        data_sram_size,
  input  logic [ADDR_W-1:0] data_sram_addr,
  input  logic [3:0]        data_sram_wstrb,
  input  logic [DATA_W-1:0] data_sram_wdata,
  output logic              data_sram_addr_ok,
  output logic              data_sram_data_ok,
  output logic [DATA_W-1:0] data_sram_rdata,

  sram_axi_bridge_if.master axi
);

  localparam int              CNT_W  = $clog2(RD_DEPTH + 1);
  localparam logic [CNT_W-1:0] RD_MAX = CNT_W'(RD_DEPTH);

  typedef enum logic {W_IDLE, W_BUSY} wr_state_e;

  wr_state_e         wr_state_q, wr_state_d;
  logic [CNT_W-1:0]  rcnt_i, rcnt_d;

  logic              ar_valid_q;
  logic [3:0]        ar_id_q;
  logic [ADDR_W-1:0] ar_addr_q;
  logic [2:0]        ar_size_q;

  logic              aw_valid_q, w_valid_q;
  logic [ADDR_W-1:0] aw_addr_q;
  logic [2:0]        aw_size_q;
  logic [DATA_W-1:0] w_data_q;
  logic [3:0]        w_strb_q;

  logic r_inst, r_data, dec_i, dec_d;
  logic slot_free, b_done, wr_free;
  logic rd_d_acc, rd_i_acc, wr_acc;

  // Response/bus status bits the bridge deliberately ignores.
  logic unused_resp;
  assign unused_resp = ^{axi.rresp, axi.rlast, axi.bresp};

  // Responses are gated by reset so nothing leaks out while the interconnect resets.
  assign r_inst = aresetn && axi.rvalid && (axi.rid == INST_ID);
  assign r_data = aresetn && axi.rvalid && (axi.rid == DATA_ID);
  assign dec_i  = r_inst && (rcnt_i != '0);
  assign dec_d  = r_data && (rcnt_d != '0);

  assign slot_free = !ar_valid_q || axi.arready;

  // The write retires only after both AW and W have handshaked on earlier edges.
  assign b_done  = (wr_state_q == W_BUSY) && !aw_valid_q && !w_valid_q &&
                   axi.bvalid && (axi.bid == DATA_ID);
  assign wr_free = (wr_state_q == W_IDLE) || b_done;

  assign rd_d_acc = aresetn && data_sram_req && !data_sram_wr && slot_free &&
                    ((rcnt_d < RD_MAX) || dec_d) && wr_free;
  assign rd_i_acc = aresetn && inst_sram_req && slot_free &&
                    ((rcnt_i < RD_MAX) || dec_i) && !rd_d_acc;
  assign wr_acc   = aresetn && data_sram_req && data_sram_wr && wr_free && (rcnt_d == '0);

  assign inst_sram_addr_ok = rd_i_acc;
  assign inst_sram_data_ok = r_inst;
  assign inst_sram_rdata   = axi.rdata;
  assign data_sram_addr_ok = rd_d_acc || wr_acc;
  assign data_sram_data_ok = r_data || b_done;
  assign data_sram_rdata   = axi.rdata;

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the pre-edge values regardless of block ordering.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rcnt_i <= '0;
      rcnt_d <= '0;
    end else begin
      unique case ({rd_i_acc, dec_i})
        2'b10:   rcnt_i <= rcnt_i + CNT_W'(1);
        2'b01:   rcnt_i <= rcnt_i - CNT_W'(1);
        default: rcnt_i <= rcnt_i;
      endcase
      unique case ({rd_d_acc, dec_d})
        2'b10:   rcnt_d <= rcnt_d + CNT_W'(1);
        2'b01:   rcnt_d <= rcnt_d - CNT_W'(1);
        default: rcnt_d <= rcnt_d;
      endcase
    end
  end

  // AR slot: a new request may overwrite it in the same cycle the old one handshakes.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      ar_valid_q <= 1'b0;
      ar_id_q    <= '0;
      ar_addr_q  <= '0;
      ar_size_q  <= '0;
    end else if (rd_d_acc) begin
      ar_valid_q <= 1'b1;
      ar_id_q    <= DATA_ID;
      ar_addr_q  <= data_sram_addr;
      ar_size_q  <= {1'b0, data_sram_size};
    end else if (rd_i_acc) begin
      ar_valid_q <= 1'b1;
      ar_id_q    <= INST_ID;
      ar_addr_q  <= inst_sram_addr;
      ar_size_q  <= {1'b0, inst_sram_size};
    end else if (axi.arready) begin
      ar_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) wr_state_q <= W_IDLE;
    else          wr_state_q <= wr_state_d;
  end

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    wr_state_d = wr_state_q;
    unique case (wr_state_q)
      W_IDLE: if (wr_acc) wr_state_d = W_BUSY;
      W_BUSY: begin
        if (wr_acc)      wr_state_d = W_BUSY;
        else if (b_done) wr_state_d = W_IDLE;
      end
      default: wr_state_d = W_IDLE;
    endcase
  end

  // AW and W valids drop independently on their own handshakes.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      aw_valid_q <= 1'b0;
      w_valid_q  <= 1'b0;
      aw_addr_q  <= '0;
      aw_size_q  <= '0;
      w_data_q   <= '0;
      w_strb_q   <= '0;
    end else if (wr_acc) begin
      aw_valid_q <= 1'b1;
      w_valid_q  <= 1'b1;
      aw_addr_q  <= data_sram_addr;
      aw_size_q  <= {1'b0, data_sram_size};
      w_data_q   <= data_sram_wdata;
      w_strb_q   <= data_sram_wstrb;
    end else begin
      if (axi.awready) aw_valid_q <= 1'b0;
      if (axi.wready)  w_valid_q  <= 1'b0;
    end
  end

  assign axi.arid    = ar_id_q;
  assign axi.araddr  = ar_addr_q;
  assign axi.arlen   = 8'd0;
  assign axi.arsize  = ar_size_q;
  assign axi.arburst = 2'b01;
  assign axi.arlock  = 2'b00;
  assign axi.arcache = 4'd0;
  assign axi.arprot  = 3'd0;
  assign axi.arvalid = ar_valid_q;
  assign axi.rready  = 1'b1;

  assign axi.awid    = DATA_ID;
  assign axi.awaddr  = aw_addr_q;
  assign axi.awlen   = 8'd0;
  assign axi.awsize  = aw_size_q;
  assign axi.awburst = 2'b01;
  assign axi.awlock  = 2'b00;
  assign axi.awcache = 4'd0;
  assign axi.awprot  = 3'd0;
  assign axi.awvalid = aw_valid_q;

  assign axi.wid     = DATA_ID;
  assign axi.wdata   = w_data_q;
  assign axi.wstrb   = w_strb_q;
  assign axi.wlast   = 1'b1;
  assign axi.wvalid  = w_valid_q;
  assign axi.bready  = 1'b1;

endmodule
